xor_crypt_controller: RTL

Sequencing FSM for the XOR-encryption datapath: key deserializer → message deserializer → XOR encrypt unit → ciphertext serializer.
- Frames the host serial load flags and counts bits.
- Gates the deserializer shift enables.
- Issues start pulses to the encrypt and serialize stages and waits for their done handshakes.
- Reports busy, status and protocol errors.

---
 rtl/xor_crypt_pkg.sv | 22 ++
 rtl/frame_bit_counter.sv | 36 +++
 rtl/xor_crypt_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/xor_crypt_pkg.sv
// Shared types and defaults for the XOR-encryption sequencing controller.
// State encodings are visible on the debug port, so they are fixed here.
package xor_crypt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_KEY  = 3'd1,
        ST_LOAD_MSG  = 3'd2,
        ST_ENCRYPT   = 3'd3,
        ST_SERIALIZE = 3'd4,
        ST_ERROR     = 3'd5
    } state_e;

    localparam int KEY_BITS_DEF    = 8;
    localparam int MSG_BITS_DEF    = 64;
    localparam int ENC_TIMEOUT_DEF = 16;

    function automatic logic is_frame_state(state_e s);
        return (s == ST_IDLE) || (s == ST_LOAD_KEY) || (s == ST_LOAD_MSG);
    endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Clear/increment counter; oLast flags that the next increment hits iLimit.
// Clear and increment together load 1 (first bit of a new frame).
module frame_bit_counter #(
    parameter int W = 7
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iClr,
    input  logic         iInc,
    input  logic [W-1:0] iLimit,
    output logic         oLast
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = iInc ? W'(1) : '0;
        end else if (iInc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oLast = ((cnt_q + W'(1)) == iLimit);

endmodule

// File: rtl/xor_crypt_controller.sv
// Sequencing FSM: key load, message load, encrypt and serialize handshakes.
// Host frames are counted bit by bit; protocol violations park in ERROR.
module xor_crypt_controller
    import xor_crypt_pkg::*;
#(
    parameter int KEY_BITS    = KEY_BITS_DEF,
    parameter int MSG_BITS    = MSG_BITS_DEF,
    parameter int ENC_TIMEOUT = ENC_TIMEOUT_DEF
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic       iLoad_key,
    input  logic       iLoad_msg,
    input  logic       iEnc_done,
    input  logic       iSer_done,
    output logic       oKey_shift_en,
    output logic       oMsg_shift_en,
    output logic       oEnc_start,
    output logic       oSer_start,
    output logic       oBusy,
    output logic       oEncryption_status,
    output logic       oDone,
    output logic       oError,
    output logic [2:0] oState
);

    localparam int BW = $clog2(MSG_BITS) + 1;
    localparam int TW = $clog2(ENC_TIMEOUT) + 1;
    localparam logic [BW-1:0] KEY_LIM = BW'(KEY_BITS);
    localparam logic [BW-1:0] MSG_LIM = BW'(MSG_BITS);
    localparam logic [TW-1:0] TO_LIM  = TW'(ENC_TIMEOUT);

    state_e state_q;
    state_e state_d;
    logic   key_valid_q;
    logic   status_q;
    logic   enc_start_q;
    logic   ser_start_q;
    logic   done_q;

    logic          key_bit;
    logic          msg_bit;
    logic          bit_last;
    logic          to_last;
    logic          bit_clr;
    logic          bit_inc;
    logic          to_clr;
    logic          to_inc;
    logic [BW-1:0] bit_lim;

    assign key_bit = iEn && iLoad_key && !iLoad_msg &&
                     ((state_q == ST_IDLE) || (state_q == ST_LOAD_KEY));
    assign msg_bit = iEn && iLoad_msg && !iLoad_key &&
                     (((state_q == ST_IDLE) && key_valid_q) ||
                      (state_q == ST_LOAD_MSG));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iLoad_key && iLoad_msg) begin
                    state_d = ST_ERROR;
                end else if (iLoad_key) begin
                    state_d = ST_LOAD_KEY;
                end else if (iLoad_msg) begin
                    state_d = key_valid_q ? ST_LOAD_MSG : ST_ERROR;
                end
            end
            ST_LOAD_KEY: begin
                if (!iLoad_key || iLoad_msg) begin
                    state_d = ST_ERROR;
                end else if (bit_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_MSG: begin
                if (!iLoad_msg || iLoad_key) begin
                    state_d = ST_ERROR;
                end else if (bit_last) begin
                    state_d = ST_ENCRYPT;
                end
            end
            ST_ENCRYPT: begin
                // a done arriving on the timeout cycle still counts
                if (iEnc_done) begin
                    state_d = ST_SERIALIZE;
                end else if (to_last) begin
                    state_d = ST_ERROR;
                end
            end
            ST_SERIALIZE: begin
                if (iSer_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (!iLoad_key && !iLoad_msg) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!iEn) begin
            state_d = state_q;
        end
    end

    assign bit_lim = (state_q == ST_LOAD_KEY) ? KEY_LIM : MSG_LIM;
    assign bit_clr = iEn && (state_d != state_q) && is_frame_state(state_d);
    assign bit_inc = (key_bit || msg_bit) && (state_d != ST_IDLE);
    assign to_clr  = iEn && (state_q != ST_ENCRYPT);
    assign to_inc  = iEn && (state_q == ST_ENCRYPT);

    frame_bit_counter #(.W(BW)) u_bit_cnt (
        .iClk   (iClk),
        .iRst   (iRst),
        .iClr   (bit_clr),
        .iInc   (bit_inc),
        .iLimit (bit_lim),
        .oLast  (bit_last)
    );

    frame_bit_counter #(.W(TW)) u_to_cnt (
        .iClk   (iClk),
        .iRst   (iRst),
        .iClr   (to_clr),
        .iInc   (to_inc),
        .iLimit (TO_LIM),
        .oLast  (to_last)
    );

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q     <= ST_IDLE;
            key_valid_q <= 1'b0;
            status_q    <= 1'b0;
            enc_start_q <= 1'b0;
            ser_start_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            enc_start_q <= 1'b0;
            ser_start_q <= 1'b0;
            done_q      <= 1'b0;
            if (iEn) begin
                state_q <= state_d;
                if (state_q == ST_LOAD_KEY && state_d == ST_IDLE) begin
                    key_valid_q <= 1'b1;
                end
                if (state_q == ST_LOAD_KEY && state_d == ST_ERROR) begin
                    key_valid_q <= 1'b0;
                end
                if (state_q == ST_IDLE && state_d == ST_LOAD_MSG) begin
                    status_q <= 1'b0;
                end
                if (state_q == ST_LOAD_MSG && state_d == ST_ENCRYPT) begin
                    enc_start_q <= 1'b1;
                end
                if (state_q == ST_ENCRYPT && state_d == ST_SERIALIZE) begin
                    ser_start_q <= 1'b1;
                    status_q    <= 1'b1;
                end
                if (state_q == ST_SERIALIZE && state_d == ST_IDLE) begin
                    done_q <= 1'b1;
                end
                if (state_d == ST_ERROR) begin
                    status_q <= 1'b0;
                end
            end
        end
    end

    assign oKey_shift_en      = key_bit;
    assign oMsg_shift_en      = msg_bit;
    assign oEnc_start         = enc_start_q;
    assign oSer_start         = ser_start_q;
    assign oDone              = done_q;
    assign oError             = (state_q == ST_ERROR);
    assign oEncryption_status = status_q;
    assign oState             = state_q;
    assign oBusy              = (state_q == ST_LOAD_MSG) ||
                                (state_q == ST_ENCRYPT) ||
                                (state_q == ST_SERIALIZE);

endmodule
